// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer that feeds a parallel word MSB-first into a SIPO shift register,
// one bit every BIT_CYCLES clocks, then captures and checks the parallel readback.
module shift_reg_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0] RegOut,
  output logic             SerOut,
  output logic             ShiftEn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DataOut,
  output logic             Match
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             match_q, match_d;
  logic             shift_en;

  // The shift pulse is the last clock of each bit's hold window.
  assign shift_en = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    match_d    = match_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          word_d  = DataIn;
          idx_d   = IDX_MSB;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (shift_en) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (!Abort) begin
          data_out_d = RegOut;
          match_d    = (RegOut == word_q);
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      match_q    <= match_d;
    end
  end

  // Serial outputs are gated by state so they drop to 0 the cycle after leaving SHIFT.
  assign SerOut  = (state_q == ST_SHIFT) ? word_q[idx_q] : 1'b0;
  assign ShiftEn = shift_en;
  assign Busy    = (state_q != ST_IDLE);
  assign Done    = done_q;
  assign DataOut = data_out_q;
  assign Match   = match_q;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Directed bench for shift_reg_seq_ctrl: one instance with BIT_CYCLES=2, one with
// BIT_CYCLES=1, each driving a behavioural 4-bit SIPO model that returns RegOut.
module tb_shift_reg_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [3:0] data_in_a, data_in_b;
  logic [3:0] reg_out_a, reg_out_b;
  logic       ser_a, shen_a, busy_a, done_a, match_a;
  logic       ser_b, shen_b, busy_b, done_b, match_b;
  logic [3:0] data_out_a, data_out_b;
  logic [3:0] sr_a, sr_b;
  logic       corrupt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  shift_reg_seq_ctrl #(.WIDTH(4), .BIT_CYCLES(2)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start_a), .Abort(abort_a),
    .DataIn(data_in_a), .RegOut(reg_out_a), .SerOut(ser_a), .ShiftEn(shen_a),
    .Busy(busy_a), .Done(done_a), .DataOut(data_out_a), .Match(match_a)
  );

  shift_reg_seq_ctrl #(.WIDTH(4), .BIT_CYCLES(1)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start_b), .Abort(abort_b),
    .DataIn(data_in_b), .RegOut(reg_out_b), .SerOut(ser_b), .ShiftEn(shen_b),
    .Busy(busy_b), .Done(done_b), .DataOut(data_out_b), .Match(match_b)
  );

  // Shift-register models: shift left, serial input enters at bit 0.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      if (shen_a) sr_a <= {sr_a[2:0], ser_a};
      if (shen_b) sr_b <= {sr_b[2:0], ser_b};
    end
  end

  assign reg_out_a = sr_a ^ {3'b000, corrupt};
  assign reg_out_b = sr_b;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    start_a = 0; abort_a = 0; data_in_a = '0;
    start_b = 0; abort_b = 0; data_in_b = '0;
    corrupt = 0;
    #3;
    n_cmp++;
    if ({ser_a, shen_a, busy_a, done_a, match_a, data_out_a} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected %b",
               {ser_a, shen_a, busy_a, done_a, match_a, data_out_a}, 9'b0);
    end
    #9 Rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got %b%b expected 00", busy_a, busy_b);
    end
  endtask

  task automatic test_nominal();
    logic [7:0] exp_ser = 8'b11001111;
    data_in_a = 4'b1011;
    start_a = 1;
    tick();
    start_a = 0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (ser_a !== exp_ser[7-i] || shen_a !== logic'(i[0]) || busy_a !== 1'b1) begin
        n_bad++;
        $display("FAIL nominal_shift cycle %0d: ser/shen/busy got %b%b%b expected %b%b1",
                 i + 1, ser_a, shen_a, busy_a, exp_ser[7-i], logic'(i[0]));
      end
      tick();
    end
    n_cmp++;
    if (busy_a !== 1'b1 || shen_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_capture: busy/shen/done got %b%b%b expected 100", busy_a, shen_a, done_a);
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b1 || data_out_a !== 4'b1011 || match_a !== 1'b1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_done: done=%b data=%b match=%b busy=%b expected 1 1011 1 0",
               done_a, data_out_a, match_a, busy_a);
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_done_pulse: done got %b expected 0", done_a);
    end
  endtask

  task automatic test_corrupt();
    corrupt = 1;
    data_in_a = 4'b1011;
    start_a = 1;
    tick();
    start_a = 0;
    repeat (9) tick();
    n_cmp++;
    if (done_a !== 1'b1 || data_out_a !== 4'b1010 || match_a !== 1'b0) begin
      n_bad++;
      $display("FAIL corrupt_readback: done=%b data=%b match=%b expected 1 1010 0",
               done_a, data_out_a, match_a);
    end
    corrupt = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    data_in_a = 4'b1100;
    start_a = 1;
    tick();
    start_a = 0;
    repeat (3) tick();
    data_in_a = 4'b0110;
    start_a = 1;
    tick();
    start_a = 0;
    n_cmp++;
    if (ser_a !== 1'b0 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start_ignored: ser/busy got %b%b expected 01", ser_a, busy_a);
    end
    repeat (4) tick();
    n_cmp++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first_capture: busy/done got %b%b expected 10", busy_a, done_a);
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b1 || data_out_a !== 4'b1100 || match_a !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_done: done=%b data=%b match=%b expected 1 1100 1",
               done_a, data_out_a, match_a);
    end
    data_in_a = 4'b0110;
    start_a = 1;
    tick();
    start_a = 0;
    n_cmp++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || ser_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_start: busy/done/ser got %b%b%b expected 100", busy_a, done_a, ser_a);
    end
    repeat (2) tick();
    n_cmp++;
    if (ser_a !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_bit2: ser got %b expected 1", ser_a);
    end
    repeat (7) tick();
    n_cmp++;
    if (done_a !== 1'b1 || data_out_a !== 4'b0110 || match_a !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_done: done=%b data=%b match=%b expected 1 0110 1",
               done_a, data_out_a, match_a);
    end
    tick();
  endtask

  task automatic test_abort();
    logic saw_done = 0;
    data_in_a = 4'b1111;
    start_a = 1;
    tick();
    start_a = 0;
    repeat (3) tick();
    n_cmp++;
    if (shen_a !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_second_shiften: shen got %b expected 1", shen_a);
    end
    abort_a = 1;
    tick();
    abort_a = 0;
    n_cmp++;
    if ({busy_a, ser_a, shen_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_idle: busy/ser/shen got %b expected 000", {busy_a, ser_a, shen_a});
    end
    repeat (10) begin
      tick();
      if (done_a || busy_a) saw_done = 1;
    end
    n_cmp++;
    if (saw_done !== 1'b0 || data_out_a !== 4'b0110 || match_a !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_no_done: activity=%b data=%b match=%b expected 0 0110 1",
               saw_done, data_out_a, match_a);
    end
    saw_done = 0;
    data_in_a = 4'b1001;
    start_a = 1;
    abort_a = 1;
    tick();
    start_a = 0;
    abort_a = 0;
    repeat (11) begin
      if (done_a || busy_a) saw_done = 1;
      tick();
    end
    n_cmp++;
    if (saw_done !== 1'b0 || data_out_a !== 4'b0110) begin
      n_bad++;
      $display("FAIL start_abort_idle: activity=%b data=%b expected 0 0110", saw_done, data_out_a);
    end
  endtask

  task automatic test_bit_cycles_1();
    logic [3:0] w = 4'b1001;
    data_in_b = w;
    start_b = 1;
    tick();
    start_b = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (shen_b !== 1'b1 || ser_b !== w[3-i]) begin
        n_bad++;
        $display("FAIL bc1_shift cycle %0d: shen/ser got %b%b expected 1%b", i + 1, shen_b, ser_b, w[3-i]);
      end
      tick();
    end
    n_cmp++;
    if (busy_b !== 1'b1 || shen_b !== 1'b0 || done_b !== 1'b0) begin
      n_bad++;
      $display("FAIL bc1_capture: busy/shen/done got %b%b%b expected 100", busy_b, shen_b, done_b);
    end
    tick();
    n_cmp++;
    if (done_b !== 1'b1 || data_out_b !== 4'b1001 || match_b !== 1'b1) begin
      n_bad++;
      $display("FAIL bc1_done: done=%b data=%b match=%b expected 1 1001 1", done_b, data_out_b, match_b);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    data_in_a = 4'b1011;
    start_a = 1;
    tick();
    start_a = 0;
    repeat (4) tick();
    n_cmp++;
    if (ser_a !== 1'b1 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_third_bit: ser/busy got %b%b expected 11", ser_a, busy_a);
    end
    Rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({ser_a, shen_a, busy_a, done_a, match_a, data_out_a} !== 9'b0) begin
      n_bad++;
      $display("FAIL async_reset_mid_shift: got %b expected %b",
               {ser_a, shen_a, busy_a, done_a, match_a, data_out_a}, 9'b0);
    end
    #2 Rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy/done got %b%b expected 00", busy_a, done_a);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_corrupt();
    test_back_to_back();
    test_abort();
    test_bit_cycles_1();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
